// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps a 10-bit PWM duty toward a handshaked target on period boundaries, with emergency stop.
module pwm_ramp_ctrl #(
  parameter int STEP = 8,
  parameter int PERIODS_PER_STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tgt_duty,
  input  logic       tgt_vld,
  output logic       tgt_rdy,
  input  logic       estop,
  output logic [9:0] duty,
  output logic       period_tick,
  output logic       at_target
);
  typedef enum logic [1:0] {IDLE, RAMP, STOP} state_t;
  localparam int PW = PERIODS_PER_STEP > 1 ? $clog2(PERIODS_PER_STEP) : 1;
  state_t state;
  logic [9:0] cnt, target, nxt;
  logic [PW-1:0] per_cnt;
  logic [10:0] up;
  logic signed [11:0] dn;
  logic step_due;
  assign period_tick = cnt == 10'h3FF;
  assign step_due = period_tick && per_cnt == PW'(PERIODS_PER_STEP - 1);
  assign tgt_rdy = state == IDLE && !estop;
  assign at_target = state == IDLE && duty == target;
  // widened arithmetic so the clamp sees overflow past 1023 and underflow below 0
  always_comb begin
    up = {1'b0, duty} + 11'(STEP);
    dn = $signed({2'b0, duty}) - $signed(12'(STEP));
    nxt = duty < target ? (up > {1'b0, target} ? target : up[9:0])
                        : (dn < $signed({2'b0, target}) ? target : dn[9:0]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      per_cnt <= '0;
      duty <= '0;
      target <= '0;
      state <= IDLE;
    end else begin
      cnt <= cnt + 10'd1;
      if (period_tick) per_cnt <= step_due ? '0 : per_cnt + 1'b1;
      if (estop) begin
        state <= STOP;
        duty <= '0;
        target <= '0;
        per_cnt <= '0;
      end else if (state == RAMP) begin
        if (step_due) begin
          duty <= nxt;
          if (nxt == target) state <= IDLE;
        end
      end else if (state == STOP) begin
        state <= IDLE;
      end else if (tgt_vld) begin
        target <= tgt_duty;
        per_cnt <= '0;
        if (tgt_duty != duty) state <= RAMP;
      end
    end
  end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed checks of ramping, clamping, estop and reset for pwm_ramp_ctrl.
module tb_pwm_ramp_ctrl;
  logic clk = 0, rst_n, estop, tgt_vld, tgt_vld2;
  logic [9:0] tgt_duty, tgt_duty2, duty, duty2;
  logic tgt_rdy, tgt_rdy2, period_tick, period_tick2, at_target, at_target2;
  int n_cmp = 0, n_err = 0, n;
  always #5 clk = ~clk;
  pwm_ramp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tgt_duty(tgt_duty), .tgt_vld(tgt_vld), .tgt_rdy(tgt_rdy),
    .estop(estop), .duty(duty), .period_tick(period_tick), .at_target(at_target)
  );
  // coarse step, one period per update: reaches the 1023 and 0 clamps in a few updates
  pwm_ramp_ctrl #(.STEP(1016), .PERIODS_PER_STEP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tgt_duty(tgt_duty2), .tgt_vld(tgt_vld2), .tgt_rdy(tgt_rdy2),
    .estop(estop), .duty(duty2), .period_tick(period_tick2), .at_target(at_target2)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_step(input string tag, input bit sel, input int exp, output int cyc);
    logic [9:0] d0;
    logic pt;
    d0 = sel ? duty2 : duty;
    cyc = 0;
    do begin
      pt = sel ? period_tick2 : period_tick;
      @(negedge clk);
      cyc++;
    end while ((sel ? duty2 : duty) == d0 && cyc < 3000);
    chk({tag, "_val"}, int'(sel ? duty2 : duty), exp);
    chk({tag, "_aligned"}, int'(pt), 1);
  endtask
  task automatic accept(input int v);
    tgt_duty = 10'(v);
    tgt_vld = 1;
    @(negedge clk);
    tgt_vld = 0;
  endtask
  task automatic accept2(input int v);
    tgt_duty2 = 10'(v);
    tgt_vld2 = 1;
    @(negedge clk);
    tgt_vld2 = 0;
  endtask
  task automatic tick_gap(input string tag, input int exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 3000);
    chk(tag, n, exp);
  endtask
  initial begin
    rst_n = 0; estop = 0; tgt_vld = 0; tgt_vld2 = 0; tgt_duty = 0; tgt_duty2 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_duty", duty, 0);
    chk("rst_rdy", tgt_rdy, 1);
    chk("rst_at_target", at_target, 1);
    chk("rst_tick", period_tick, 0);
    tick_gap("first_tick", 1023);
    tick_gap("tick_period", 1024);
    accept(100);
    chk("acc_rdy_low", tgt_rdy, 0);
    chk("acc_at_target_low", at_target, 0);
    tgt_duty = 500;
    tgt_vld = 1;
    @(negedge clk);
    tgt_vld = 0;
    for (int k = 1; k <= 13; k++) begin
      wait_step($sformatf("up%0d", k), 0, k < 13 ? 8 * k : 100, n);
      if (k > 1) chk($sformatf("up_gap%0d", k), n, 2048);
    end
    chk("up_done_rdy", tgt_rdy, 1);
    chk("up_done_at_target", at_target, 1);
    accept(100);
    chk("same_tgt_rdy", tgt_rdy, 1);
    chk("same_tgt_duty", duty, 100);
    chk("same_tgt_at_target", at_target, 1);
    accept(0);
    chk("dn_rdy_low", tgt_rdy, 0);
    for (int k = 1; k <= 13; k++) begin
      wait_step($sformatf("dn%0d", k), 0, k < 13 ? 100 - 8 * k : 0, n);
      if (k > 1) chk($sformatf("dn_gap%0d", k), n, 2048);
    end
    chk("dn_done_at_target", at_target, 1);
    accept(100);
    for (int k = 1; k <= 6; k++) wait_step($sformatf("pre_stop%0d", k), 0, 8 * k, n);
    estop = 1;
    tgt_duty = 300;
    tgt_vld = 1;
    #1 chk("estop_rdy_comb", tgt_rdy, 0);
    @(negedge clk);
    chk("estop_duty", duty, 0);
    chk("estop_rdy", tgt_rdy, 0);
    chk("estop_at_target", at_target, 0);
    repeat (5) @(negedge clk);
    chk("estop_hold", duty, 0);
    estop = 0;
    tgt_vld = 0;
    @(negedge clk);
    chk("estop_exit_rdy", tgt_rdy, 1);
    chk("estop_exit_at_target", at_target, 1);
    chk("estop_exit_duty", duty, 0);
    accept(200);
    chk("ramp_again", at_target, 0);
    #2 rst_n = 0;
    #2 rst_n = 1;
    @(negedge clk);
    chk("glitch_rdy", tgt_rdy, 0);
    chk("glitch_at_target", at_target, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst2_duty", duty, 0);
    chk("rst2_rdy", tgt_rdy, 1);
    chk("rst2_at_target", at_target, 1);
    tick_gap("rst2_first_tick", 1023);
    accept2(1016);
    wait_step("sat_a", 1, 1016, n);
    accept2(1023);
    wait_step("sat_b", 1, 1023, n);
    chk("sat_at_target", at_target2, 1);
    accept2(0);
    wait_step("clamp_a", 1, 7, n);
    wait_step("clamp_b", 1, 0, n);
    chk("clamp_at_target", at_target2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
